// File: rtl/dvp_pkg.sv
// Shared types, default timing and the RGB888 -> RGB565 byte packing for the DVP transmitter.
package dvp_pkg;

  localparam int DVP_H_ACTIVE  = 1280;
  localparam int DVP_H_BLANK   = 256;
  localparam int DVP_V_ACTIVE  = 720;
  localparam int DVP_VS_LINES  = 4;
  localparam int DVP_VBP_LINES = 16;
  localparam int DVP_VFP_LINES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } dvp_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Returns {byte0, byte1} in OV5640 RGB565 wire order.
  function automatic logic [15:0] rgb888_to_565(input rgb888_t p);
    return {p.r[7:3], p.g[7:5], p.g[4:2], p.b[7:3]};
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame/line sequencer: FSM plus h/v counters, decoding what the next output cycle will carry.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = DVP_H_ACTIVE,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int V_ACTIVE  = DVP_V_ACTIVE,
  parameter int VS_LINES  = DVP_VS_LINES,
  parameter int VBP_LINES = DVP_VBP_LINES,
  parameter int VFP_LINES = DVP_VFP_LINES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_en,
  output logic href_nxt,
  output logic vsync_nxt,
  output logic phase_nxt,
  output logic first_pixel,
  output logic frame_start_nxt,
  output logic pix_slot
);

  localparam int LL   = 2*H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(LL);
  localparam int MAXL = max4(VS_LINES, VBP_LINES, V_ACTIVE, VFP_LINES);
  localparam int VW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(LL-1);
  localparam logic [HW:0]   H_ACT_END = (HW+1)'(2*H_ACTIVE);

  dvp_state_e      state, state_nxt;
  logic [HW-1:0]   h_cnt, h_nxt;
  logic [VW-1:0]   v_cnt, v_nxt;
  logic            last_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // State only advances on a line wrap; IDLE parks the counters at the line start.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt + 1'b1;
    v_nxt     = v_cnt;
    last_line = 1'b0;
    case (state)
      ST_VSYNC:  last_line = (v_cnt == VW'(VS_LINES-1));
      ST_VBP:    last_line = (v_cnt == VW'(VBP_LINES-1));
      ST_ACTIVE: last_line = (v_cnt == VW'(V_ACTIVE-1));
      ST_VFP:    last_line = (v_cnt == VW'(VFP_LINES-1));
      default:   last_line = 1'b0;
    endcase
    if (state == ST_IDLE) begin
      h_nxt = '0;
      v_nxt = '0;
      if (tx_en) state_nxt = ST_VSYNC;
    end else if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (last_line) begin
        v_nxt = '0;
        case (state)
          ST_VSYNC:  state_nxt = ST_VBP;
          ST_VBP:    state_nxt = ST_ACTIVE;
          ST_ACTIVE: state_nxt = ST_VFP;
          ST_VFP:    state_nxt = tx_en ? ST_VSYNC : ST_IDLE;
          default:   state_nxt = ST_IDLE;
        endcase
      end else begin
        v_nxt = v_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    href_nxt        = (state_nxt == ST_ACTIVE) && ({1'b0, h_nxt} < H_ACT_END);
    vsync_nxt       = (state_nxt == ST_VSYNC);
    phase_nxt       = h_nxt[0];
    frame_start_nxt = vsync_nxt && (h_nxt == '0) && (v_nxt == '0);
    first_pixel     = (state_nxt == ST_ACTIVE) && (h_nxt == '0) && (v_nxt == '0);
    pix_slot        = href_nxt && !h_nxt[0];
  end

endmodule

// File: rtl/ov5640_dvp_tx.sv
// OV5640-style DVP transmitter: RGB888 stream in, vsync/href/RGB565 bytes out, with sticky error flags.
module ov5640_dvp_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = DVP_H_ACTIVE,
  parameter int H_BLANK   = DVP_H_BLANK,
  parameter int V_ACTIVE  = DVP_V_ACTIVE,
  parameter int VS_LINES  = DVP_VS_LINES,
  parameter int VBP_LINES = DVP_VBP_LINES,
  parameter int VFP_LINES = DVP_VFP_LINES
) (
  input  logic        sys_clk_25m,
  input  logic        sys_rst_n,
  input  logic        tx_en,
  input  logic        s_valid,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  output logic        s_ready,
  output logic        frame_start,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        underrun,
  output logic        sync_err,
  input  logic        err_clr
);

  logic        href_nxt, vsync_nxt, phase_nxt, first_pixel, fs_nxt, pix_slot;
  logic        xfer;
  logic [15:0] in565;
  logic [7:0]  hold_b1;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .VS_LINES (VS_LINES),
    .VBP_LINES(VBP_LINES),
    .VFP_LINES(VFP_LINES)
  ) u_timing (
    .clk            (sys_clk_25m),
    .rst_n          (sys_rst_n),
    .tx_en          (tx_en),
    .href_nxt       (href_nxt),
    .vsync_nxt      (vsync_nxt),
    .phase_nxt      (phase_nxt),
    .first_pixel    (first_pixel),
    .frame_start_nxt(fs_nxt),
    .pix_slot       (pix_slot)
  );

  assign s_ready = pix_slot;
  assign xfer    = s_valid && s_ready;
  assign in565   = rgb888_to_565(rgb888_t'(s_data));

  // byte0 bypasses straight from the input so it lands one cycle after the transfer;
  // only byte1 needs holding. An empty slot holds zero so both bytes go out as 0x00.
  always_ff @(posedge sys_clk_25m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
      dvp_vsync   <= 1'b0;
      dvp_href    <= 1'b0;
      dvp_data    <= '0;
      hold_b1     <= '0;
      underrun    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_start <= fs_nxt;
      dvp_vsync   <= vsync_nxt;
      dvp_href    <= href_nxt;
      if (s_ready) hold_b1 <= s_valid ? in565[7:0] : 8'h00;
      if (!href_nxt)       dvp_data <= 8'h00;
      else if (!phase_nxt) dvp_data <= xfer ? in565[15:8] : 8'h00;
      else                 dvp_data <= hold_b1;
      if (s_ready && !s_valid)             underrun <= 1'b1;
      else if (err_clr)                    underrun <= 1'b0;
      if (xfer && (s_sof != first_pixel))  sync_err <= 1'b1;
      else if (err_clr)                    sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Scoreboard bench: driver pushes expected bytes with due cycle, monitor pops on every href cycle.
module tb_ov5640_dvp_tx;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_ready, frame_start, dvp_vsync, dvp_href, underrun, sync_err;
  logic [7:0]  dvp_data;
  logic        clr_pulse = 1'b0;
  logic        sof_clr = 1'b0;
  logic        err_clr;

  assign err_clr = clr_pulse | sof_clr;

  ov5640_dvp_tx #(
    .H_ACTIVE(4), .H_BLANK(3), .V_ACTIVE(2),
    .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .sys_clk_25m(clk), .sys_rst_n(sys_rst_n), .tx_en(tx_en),
    .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof), .s_ready(s_ready),
    .frame_start(frame_start), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
    .dvp_data(dvp_data), .underrun(underrun), .sync_err(sync_err), .err_clr(err_clr)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          drop_pix = -1;
  int          sof_pix = -1;
  logic        sof_first = 1'b1;
  logic        clr_with_err = 1'b0;
  int          pix = 0;

  // Hand-computed RGB565 {byte0,byte1} for each test pixel.
  logic [23:0] px_tab [8] = '{24'hFF8040, 24'h000000, 24'hFFFFFF, 24'h123456,
                              24'h00FC00, 24'h0000F8, 24'hF80000, 24'hA5C33C};
  logic [15:0] exp_tab[8] = '{16'hFC08, 16'h0000, 16'hFFFF, 16'h11AA,
                              16'h07E0, 16'h001F, 16'hF800, 16'hA607};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: presents a pixel on every s_ready cycle and records the bytes it should produce.
  always @(negedge clk) begin
    int idx;
    logic v;
    if (frame_start) pix = 0;
    sof_clr = 1'b0;
    if (s_ready) begin
      idx = pix % 8;
      v = (pix != drop_pix);
      s_valid = v;
      s_data  = px_tab[idx];
      s_sof   = (pix == 0 && sof_first) || (pix == sof_pix);
      if (clr_with_err && pix == sof_pix) sof_clr = 1'b1;
      sb.push_back('{d: v ? exp_tab[idx][15:8] : 8'h00, cyc: cyc + 1});
      sb.push_back('{d: v ? exp_tab[idx][7:0]  : 8'h00, cyc: cyc + 2});
      pix++;
    end else begin
      s_valid = 1'b1;
      s_data  = 24'h5A5A5A;
      s_sof   = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (sys_rst_n) begin
      if (dvp_href) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_byte", {24'h0, dvp_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("data", {24'h0, dvp_data}, {24'h0, e.d});
          chk("latency", cyc, e.cyc);
        end
      end else begin
        chk("data_idle", {24'h0, dvp_data}, 32'h0);
      end
    end
  end

  task automatic wait_fs();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start) break;
    end
    if (i == 200) chk("frame_start_timeout", 0, 1);
  endtask

  // Called on a frame_start sample; returns on the following frame's frame_start sample.
  task automatic measure_frame(input string tag);
    int vs = 0, hr = 0, rd = 0, bursts = 0;
    logic prev = 1'b0;
    chk({tag, "_vsync_first"}, dvp_vsync, 1);
    for (int i = 0; i < 55; i++) begin
      vs += dvp_vsync;
      hr += dvp_href;
      rd += s_ready;
      if (dvp_href && !prev) bursts++;
      prev = dvp_href;
      @(negedge clk);
    end
    chk({tag, "_vsync_cycles"}, vs, 11);
    chk({tag, "_href_cycles"}, hr, 16);
    chk({tag, "_href_bursts"}, bursts, 2);
    chk({tag, "_ready_cycles"}, rd, 8);
    chk({tag, "_period"}, frame_start, 1);
  endtask

  task automatic pulse_clr();
    clr_pulse = 1'b1;
    @(negedge clk);
    clr_pulse = 1'b0;
  endtask

  initial begin
    int vs, hr, fs;
    repeat (5) @(negedge clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("reset_idle_outs", {s_ready, frame_start, dvp_vsync, dvp_href, dvp_data, underrun, sync_err}, 0);
    end

    tx_en = 1'b1;
    wait_fs();
    measure_frame("f1");
    chk("no_underrun", underrun, 0);
    chk("no_sync_err", sync_err, 0);

    drop_pix = 2;
    measure_frame("drop");
    chk("underrun_set", underrun, 1);
    drop_pix = -1;
    measure_frame("f3");
    chk("underrun_sticky", underrun, 1);
    pulse_clr();
    chk("underrun_clr", underrun, 0);

    sof_pix = 2;
    wait_fs();
    chk("sync_err_sof_late", sync_err, 1);
    sof_pix = -1;
    pulse_clr();
    chk("sync_err_clr", sync_err, 0);
    sof_pix = 2;
    clr_with_err = 1'b1;
    wait_fs();
    chk("sync_err_set_wins", sync_err, 1);
    sof_pix = -1;
    clr_with_err = 1'b0;
    pulse_clr();
    chk("sync_err_clr2", sync_err, 0);
    sof_first = 1'b0;
    wait_fs();
    chk("sync_err_missing_sof", sync_err, 1);
    sof_first = 1'b1;
    pulse_clr();
    chk("sync_err_clr3", sync_err, 0);

    // Drop tx_en in the middle of the second active line.
    wait_fs();
    vs = 0; hr = 0; fs = 0;
    for (int i = 0; i < 250; i++) begin
      if (i == 36) tx_en = 1'b0;
      vs += dvp_vsync;
      hr += dvp_href;
      fs += frame_start;
      @(negedge clk);
    end
    chk("txen_drop_vsync", vs, 11);
    chk("txen_drop_href", hr, 16);
    chk("txen_drop_frames", fs, 1);
    chk("txen_drop_sb_empty", sb.size(), 0);

    // Reset in the middle of an active line.
    tx_en = 1'b1;
    wait_fs();
    repeat (25) @(negedge clk);
    #1 sys_rst_n = 1'b0;
    #1 chk("midreset_outs", {s_ready, frame_start, dvp_vsync, dvp_href, dvp_data, underrun, sync_err}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    #1 sys_rst_n = 1'b1;
    @(negedge clk);
    chk("restart_frame_start", frame_start, 1);
    measure_frame("restart");
    tx_en = 1'b0;
    repeat (70) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
